// File: rtl/svi_force_array_ctrl.sv
// svi_force_array_ctrl: per-lane override of NUM_CH x WIDTH driver lanes.
// Each lane passes its input through, or is overridden with all-0, all-1 or
// all-z. A timed override releases itself after a given number of cycles.
// A held override stays until an explicit release. The global 'en' input
// forces every lane to z combinationally without touching any lane state.
module svi_force_array_ctrl #(
    parameter  int NUM_CH = 8,
    parameter  int WIDTH  = 1,
    parameter  int DUR_W  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_arst_n,
    input  logic                          en,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  i_data,
    output logic [NUM_CH-1:0][WIDTH-1:0]  o_data,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [CH_W-1:0]               i_cmd_ch,
    input  logic [1:0]                    i_cmd_op,
    input  logic [DUR_W-1:0]              i_cmd_dur,
    output logic [NUM_CH-1:0]             o_forced,
    output logic [NUM_CH-1:0]             o_expired,
    output logic                          o_cmd_err
);

    typedef enum logic [1:0] {
        REL       = 2'd0,
        FRC_TIMED = 2'd1,
        FRC_HOLD  = 2'd2
    } lane_state_t;

    localparam logic [1:0]  OP_REL    = 2'b00;
    localparam logic [1:0]  OP_ZERO   = 2'b01;
    localparam logic [1:0]  OP_ONE    = 2'b10;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic cmd_accept;
    logic ch_valid;
    logic cmd_err_reg;

    // Commands are refused while every lane is being forced to z.
    assign o_cmd_ready = !en;
    assign cmd_accept  = i_cmd_valid && o_cmd_ready;
    // Extra MSB lets the comparison work when NUM_CH is a power of two.
    assign ch_valid    = ({1'b0, i_cmd_ch} < NUM_CH_L);
    assign o_cmd_err   = cmd_err_reg;

    // Flag an accepted command that targets a lane that does not exist.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cmd_err_reg <= 1'b0;
        end else begin
            cmd_err_reg <= cmd_accept && !ch_valid;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            lane_state_t      state_reg;
            logic [DUR_W-1:0] cnt_reg;
            logic [1:0]       val_reg;   // stored override kind, decoded below
            logic             expired_reg;
            logic             hit;
            logic [WIDTH-1:0] force_val;

            assign hit = cmd_accept && ch_valid && (i_cmd_ch == CH_W'(gi));

            // Lane FSM: a command to this lane always wins over its own expiry.
            always_ff @(posedge i_clk or negedge i_arst_n) begin
                if (!i_arst_n) begin
                    state_reg   <= REL;
                    cnt_reg     <= '0;
                    val_reg     <= OP_REL;
                    expired_reg <= 1'b0;
                end else begin
                    expired_reg <= 1'b0;
                    if (hit) begin
                        if (i_cmd_op == OP_REL) begin
                            state_reg <= REL;
                            cnt_reg   <= '0;
                        end else begin
                            val_reg <= i_cmd_op;
                            if (i_cmd_dur == '0) begin
                                state_reg <= FRC_HOLD;
                                cnt_reg   <= '0;
                            end else begin
                                state_reg <= FRC_TIMED;
                                cnt_reg   <= i_cmd_dur;
                            end
                        end
                    end else if (state_reg == FRC_TIMED) begin
                        if (cnt_reg == DUR_W'(1)) begin
                            state_reg   <= REL;
                            cnt_reg     <= '0;
                            expired_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - DUR_W'(1);
                        end
                    end
                end
            end

            assign o_forced[gi]  = (state_reg != REL);
            assign o_expired[gi] = expired_reg;

            // Replicate the stored override kind across the lane width.
            assign force_val = (val_reg == OP_ZERO) ? {WIDTH{1'b0}} :
                               (val_reg == OP_ONE)  ? {WIDTH{1'b1}} :
                                                      {WIDTH{1'bz}};

            // Output priority: global z, then lane override, then pass-through.
            assign o_data[gi] = en           ? {WIDTH{1'bz}} :
                                o_forced[gi] ? force_val     :
                                               i_data[gi];
        end
    endgenerate

endmodule

// File: tb/tb_svi_force_array_ctrl.sv
// Bench for svi_force_array_ctrl: two instances (8x1 and 6x4) driven with
// directed scenarios followed by random traffic, checked every cycle against
// a model that tracks each override as an absolute end cycle.
module tb_svi_force_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en    [2];
    logic        valid [2];
    logic [2:0]  ch    [2];
    logic [1:0]  op    [2];
    logic [7:0]  dur   [2];
    logic [31:0] din   [2];

    logic [7:0]  dout_a;
    logic [23:0] dout_b;
    logic        rdy_a, rdy_b;
    logic [7:0]  frc_a, exp_a;
    logic [5:0]  frc_b, exp_b;
    logic        err_a, err_b;

    svi_force_array_ctrl #(.NUM_CH(8), .WIDTH(1), .DUR_W(8)) u_dut_a (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .en          (en[0]),
        .i_data      (din[0][7:0]),
        .o_data      (dout_a),
        .i_cmd_valid (valid[0]),
        .o_cmd_ready (rdy_a),
        .i_cmd_ch    (ch[0]),
        .i_cmd_op    (op[0]),
        .i_cmd_dur   (dur[0]),
        .o_forced    (frc_a),
        .o_expired   (exp_a),
        .o_cmd_err   (err_a)
    );

    svi_force_array_ctrl #(.NUM_CH(6), .WIDTH(4), .DUR_W(8)) u_dut_b (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .en          (en[1]),
        .i_data      (din[1][23:0]),
        .o_data      (dout_b),
        .i_cmd_valid (valid[1]),
        .o_cmd_ready (rdy_b),
        .i_cmd_ch    (ch[1]),
        .i_cmd_op    (op[1]),
        .i_cmd_dur   (dur[1]),
        .o_forced    (frc_b),
        .o_expired   (exp_b),
        .o_cmd_err   (err_b)
    );

    // Reference model: an override is forced while cyc < end_c (or hold is set).
    int         cyc;
    int         end_c [2][8];
    bit         hold  [2][8];
    logic [1:0] fop   [2][8];
    bit         expm  [2][8];
    bit         errm  [2];

    int n_checks = 0;
    int n_err    = 0;

    function automatic int nch(int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic int wid(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit lane_forced(int k, int i);
        return hold[k][i] || (cyc < end_c[k][i]);
    endfunction

    function automatic logic [31:0] exp_data(int k);
        logic [31:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < nch(k); i++) begin
            for (int b = 0; b < wid(k); b++) begin
                idx = i * wid(k) + b;
                if (en[k])                      r[idx] = 1'bz;
                else if (lane_forced(k, i)) begin
                    if (fop[k][i] == 2'b01)      r[idx] = 1'b0;
                    else if (fop[k][i] == 2'b10) r[idx] = 1'b1;
                    else                         r[idx] = 1'bz;
                end else                         r[idx] = din[k][idx];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_forced(int k);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < nch(k); i++) r[i] = lane_forced(k, i);
        return r;
    endfunction

    function automatic logic [7:0] exp_expired(int k);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < nch(k); i++) r[i] = expm[k][i];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            errm[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                end_c[k][i] = 0;
                hold[k][i]  = 1'b0;
                fop[k][i]   = 2'b00;
                expm[k][i]  = 1'b0;
            end
        end
    endtask

    // Apply one clock edge to instance k's model (cyc already advanced).
    task automatic model_edge(int k);
        bit acc;
        bit hit;
        acc = valid[k] && !en[k];
        if (acc)
            $display("cmd inst=%0d ch=%0d op=%0d dur=%0d cyc=%0d", k, ch[k], op[k], dur[k], cyc);
        errm[k] = acc && (int'(ch[k]) >= nch(k));
        for (int i = 0; i < nch(k); i++) begin
            hit = acc && (int'(ch[k]) == i);
            expm[k][i] = 1'b0;
            if (hit) begin
                if (op[k] == 2'b00) begin
                    hold[k][i]  = 1'b0;
                    end_c[k][i] = 0;
                end else begin
                    fop[k][i]   = op[k];
                    hold[k][i]  = (dur[k] == 8'd0);
                    end_c[k][i] = (dur[k] == 8'd0) ? 0 : cyc + int'(dur[k]);
                end
            end else if (!hold[k][i] && end_c[k][i] == cyc) begin
                expm[k][i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("a_data",    {32'b0, 24'b0, dout_a}, {32'b0, exp_data(0)});
        chk("a_forced",  {56'b0, frc_a}, {56'b0, exp_forced(0)});
        chk("a_expired", {56'b0, exp_a}, {56'b0, exp_expired(0)});
        chk("a_err",     {63'b0, err_a}, {63'b0, errm[0]});
        chk("a_ready",   {63'b0, rdy_a}, {63'b0, !en[0]});
        chk("b_data",    {32'b0, 8'b0, dout_b}, {32'b0, exp_data(1)});
        chk("b_forced",  {58'b0, frc_b}, {56'b0, exp_forced(1)});
        chk("b_expired", {58'b0, exp_b}, {56'b0, exp_expired(1)});
        chk("b_err",     {63'b0, err_b}, {63'b0, errm[1]});
        chk("b_ready",   {63'b0, rdy_b}, {63'b0, !en[1]});
    endtask

    task automatic cmd(int k, bit v, int c, int o, int d);
        valid[k] = v;
        ch[k]    = 3'(c);
        op[k]    = 2'(o);
        dur[k]   = 8'(d);
    endtask

    // Check combinational response to the new inputs, take one edge, check again.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 2; k++) begin
            en[k]  = 1'b0;
            din[k] = '0;
            cmd(k, 0, 0, 0, 0);
        end
        model_reset();
        #1;
        check_all();
        #2;
        rst_n = 1'b1;

        // Reset mid-override: lane 3 held at z, then async reset between edges.
        din[0] = 8'h08;
        cmd(0, 1, 3, 3, 0); tick();
        cmd(0, 0, 0, 0, 0); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;

        // Timed force-0 on lane 2 with all-ones input.
        din[0] = 32'hFF;
        cmd(0, 1, 2, 1, 3); tick();
        cmd(0, 0, 0, 0, 0);
        repeat (5) tick();

        // Hold z on lane 5 for 100 cycles, then release.
        cmd(0, 1, 5, 3, 0); tick();
        cmd(0, 0, 0, 0, 0);
        repeat (100) tick();
        cmd(0, 1, 5, 0, 0); tick();
        cmd(0, 0, 0, 0, 0);
        repeat (2) tick();

        // Expiry collision on lane 1: new command lands on the expiry edge.
        cmd(0, 1, 1, 2, 2); tick();
        cmd(0, 0, 0, 0, 0); tick();
        cmd(0, 1, 1, 2, 4); tick();
        chk("collision_no_expire", {63'b0, exp_a[1]}, 64'd0);
        cmd(0, 0, 0, 0, 0);
        repeat (6) tick();

        // Global en while lanes 0 and 7 are in timed force; a command offered
        // during en must be ignored.
        din[0] = 32'h5A;
        cmd(0, 1, 0, 1, 6); tick();
        cmd(0, 1, 7, 2, 6); tick();
        en[0] = 1'b1;
        cmd(0, 1, 4, 1, 3); tick();
        cmd(0, 0, 0, 0, 0); tick();
        en[0] = 1'b0;
        repeat (6) tick();

        // 6-lane, 4-bit instance: bad index, then force-1 on lane 3.
        din[1] = 32'h0012_3456;
        cmd(1, 1, 7, 1, 0); tick();
        cmd(1, 0, 0, 0, 0); tick();
        cmd(1, 1, 3, 2, 2); tick();
        chk("b_lane3_ones", {60'b0, dout_b[15:12]}, 64'hF);
        cmd(1, 0, 0, 0, 0);
        repeat (3) tick();

        // Random traffic on both instances.
        repeat (400) begin
            for (int k = 0; k < 2; k++) begin
                cmd(k, $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6));
                en[k]  = ($urandom_range(0, 9) == 0);
                din[k] = $urandom;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/svi_force_array_ctrl.md
Name: svi_force_array_ctrl

Overview:
- Parametrised successor to the fixed 8-lane force/release-to-z block.
- Sits between NUM_CH driver lanes of WIDTH bits and their consumers.
- Each lane passes its input through, or is overridden with all-0, all-1 or all-z.
- Overrides are set by a valid/ready command port, either timed (auto-release after N cycles) or held until an explicit release; a global enable forces every lane to z combinationally.

Parameters:
- NUM_CH, 8, number of lanes (>=1).
- WIDTH, 1, bits per lane.
- DUR_W, 8, width of the duration field and per-lane down-counter.

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_arst_n  input  1  asynchronous, active-low reset.
- en  input  1  global force-to-z, combinational, highest priority.
- i_data  input  NUM_CH x WIDTH  lane inputs (4-state logic).
- o_data  output  NUM_CH x WIDTH  lane outputs (4-state logic).
- i_cmd_valid  input  1  command valid.
- o_cmd_ready  output  1  command ready.
- i_cmd_ch  input  max(1,$clog2(NUM_CH))  target lane index.
- i_cmd_op  input  2  00 release, 01 force 0, 10 force 1, 11 force z.
- i_cmd_dur  input  DUR_W  duration in cycles; 0 = hold until release.
- o_forced  output  NUM_CH  lane override active (registered state, excludes en).
- o_expired  output  NUM_CH  one-cycle pulse when a timed override auto-releases.
- o_cmd_err  output  1  one-cycle pulse when an accepted command has i_cmd_ch >= NUM_CH.

Behaviour:
- Reset (async assert, sync-to-clock deassert not required):
  - All lanes enter REL; counters and stored values are 0.
  - o_forced = 0, o_expired = 0, o_cmd_err = 0.
- o_cmd_ready = !en (combinational); commands are not accepted while en = 1.
- Accept = i_cmd_valid && o_cmd_ready at a rising edge. At most one command per cycle.
- Per-lane FSM states are REL, FRC_TIMED and FRC_HOLD.
- On accept with op != 00 to a valid lane:
  - Store the force value: all 0, all 1 or all z, replicated across WIDTH.
  - dur = 0: go to FRC_HOLD.
  - dur > 0: go to FRC_TIMED with cnt = dur.
  - This applies from any state; a new command restarts the override and replaces the value.
- On accept with op = 00 to a valid lane: go to REL and clear cnt. No o_expired pulse. Releasing a lane already in REL has no effect.
- FRC_TIMED on each edge without a command to that lane:
  - cnt == 1: go to REL and set o_expired[lane] = 1 for the next cycle only.
  - otherwise: cnt <= cnt - 1.
- The forced value appears on o_data for exactly dur cycles, starting the cycle after the accept edge.
- A command to a lane on the same edge as its expiry takes priority: the command takes effect and no o_expired pulse is generated.
- Invalid lane index: the command is accepted, no lane state changes, and o_cmd_err pulses for one cycle.
- o_data[i], combinational, in priority order:
  - en = 1 → all z.
  - lane forced → stored value.
  - otherwise → i_data[i].
- en does not alter FSM state or counters. Timed counters keep running while en = 1.
- o_forced[i] = 1 in FRC_TIMED or FRC_HOLD.
- NUM_CH = 1: the channel field is 1 bit, and index 1 is invalid.
- Lane latency: zero for both data pass-through and en; one cycle for a command to take effect.

Test Plan:
- Reset mid-override: lane 3 in FRC_HOLD, assert i_arst_n = 0 between edges → o_forced = 0 and o_data[3] = i_data[3] immediately, with no clock needed.
- Timed force: accept ch=2 op=01 dur=3 with i_data = all 1 → o_data[2] = 0 for exactly 3 cycles, then o_expired[2] pulses once and o_data[2] = 1. Other lanes unaffected.
- Hold and release: ch=5 op=11 dur=0 → o_data[5] = z for 100 cycles. Then ch=5 op=00 → next cycle passes through, o_forced[5] = 0, no o_expired pulse.
- Expiry collision: ch=1 dur=2, then on its expiry edge issue ch=1 op=10 dur=4 → no o_expired pulse; o_data[1] = 1 for 4 cycles.
- Global en: lanes 0 and 7 in timed force, assert en for 2 cycles → all o_data = z and o_cmd_ready = 0, counters keep decrementing. After en drops, the remaining override time is observed as correct.
- Bad index with NUM_CH=6: accept ch=7 → o_cmd_err pulses once and all o_forced are unchanged. Also check WIDTH=4: a force-1 drives 4'b1111.
